// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one byte-wide synchronous memory port between the CPU
// core and the VIDAC. Each side uses a level req with a one-cycle ack. Every
// access takes three states: IDLE (arbitrate and register the port),
// ISSUE (memory samples the port) and WAIT (capture read data, pulse ack).
module mem_arbiter #(
  parameter logic [19:0] VID_BASE   = 20'hA0000,
  parameter bit          FIXED_PRIO = 1'b0
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [19:0] cpu_a,
  input  logic [7:0]  cpu_o,
  output logic [7:0]  cpu_i,
  output logic        cpu_ack,
  input  logic        vid_req,
  input  logic        vid_we,
  input  logic [17:0] vid_a,
  input  logic [7:0]  vid_o,
  output logic [7:0]  vid_i,
  output logic        vid_ack,
  output logic [19:0] mem_a,
  output logic [7:0]  mem_o,
  output logic        mem_w,
  input  logic [7:0]  mem_i,
  output logic        busy
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;

  // r_last_vid: 1 when the most recent grant went to the VIDAC.
  // r_win_vid:  owner of the access currently in ISSUE/WAIT.
  logic        r_last_vid;
  logic        r_win_vid;
  logic [19:0] r_mem_a;
  logic [7:0]  r_mem_o;
  logic        r_mem_w;
  logic [7:0]  r_cpu_i;
  logic [7:0]  r_vid_i;
  logic        r_cpu_ack;
  logic        r_vid_ack;

  logic        w_cpu_elig;
  logic        w_vid_elig;
  logic        w_issue;
  logic        w_pick_vid;
  logic        w_done;

  // VIDAC offset to physical address; the sum wraps inside 20 bits.
  function automatic logic [19:0] vid_phys(input logic [17:0] a);
    return VID_BASE + {2'b00, a};
  endfunction

  // A requester whose ack is high this cycle still shows its old req;
  // masking it keeps that stale req from winning a second grant.
  assign w_cpu_elig = cpu_req & ~r_cpu_ack;
  assign w_vid_elig = vid_req & ~r_vid_ack;

  // State register
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state, arbitration decision and per-state strobes
  always_comb begin
    w_state_nxt = r_state;
    w_issue     = 1'b0;
    w_pick_vid  = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_cpu_elig || w_vid_elig) begin
          w_issue     = 1'b1;
          w_state_nxt = ST_ISSUE;
          if (!w_cpu_elig) begin
            w_pick_vid = 1'b1;
          end else if (!w_vid_elig) begin
            w_pick_vid = 1'b0;
          end else if (FIXED_PRIO) begin
            w_pick_vid = 1'b0;
          end else begin
            // Tie under round-robin: whoever did not win last time.
            w_pick_vid = ~r_last_vid;
          end
        end
      end
      ST_ISSUE: begin
        w_state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        w_done      = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Memory port, grant history, returned data and ack pulses
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_last_vid <= 1'b1;
      r_win_vid  <= 1'b0;
      r_mem_a    <= '0;
      r_mem_o    <= '0;
      r_mem_w    <= 1'b0;
      r_cpu_i    <= '0;
      r_vid_i    <= '0;
      r_cpu_ack  <= 1'b0;
      r_vid_ack  <= 1'b0;
    end else begin
      r_cpu_ack <= 1'b0;
      r_vid_ack <= 1'b0;
      if (w_issue) begin
        r_win_vid  <= w_pick_vid;
        r_last_vid <= w_pick_vid;
        if (w_pick_vid) begin
          r_mem_a <= vid_phys(vid_a);
          r_mem_o <= vid_o;
          r_mem_w <= vid_we;
        end else begin
          r_mem_a <= cpu_a;
          r_mem_o <= cpu_o;
          r_mem_w <= cpu_we;
        end
      end else begin
        // Write strobe lives only in ISSUE; address and data hold.
        r_mem_w <= 1'b0;
      end
      if (w_done) begin
        if (r_win_vid) begin
          r_vid_i   <= mem_i;
          r_vid_ack <= 1'b1;
        end else begin
          r_cpu_i   <= mem_i;
          r_cpu_ack <= 1'b1;
        end
      end
    end
  end

  assign mem_a   = r_mem_a;
  assign mem_o   = r_mem_o;
  assign mem_w   = r_mem_w;
  assign cpu_i   = r_cpu_i;
  assign vid_i   = r_vid_i;
  assign cpu_ack = r_cpu_ack;
  assign vid_ack = r_vid_ack;
  assign busy    = (r_state != ST_IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: two arbiters (round-robin at base A0000, fixed priority at
// base F0000) each with a synchronous byte memory. Requester threads push the
// expected response into per-requester queues; a negedge monitor pops and
// compares whenever an ack appears.
`timescale 1ns/1ps
module tb_mem_arbiter;

  localparam logic [19:0] BASE0 = 20'hA0000;
  localparam logic [19:0] BASE1 = 20'hF0000;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  logic        cpu_req [2];
  logic        cpu_we  [2];
  logic [19:0] cpu_a   [2];
  logic [7:0]  cpu_o   [2];
  logic        vid_req [2];
  logic        vid_we  [2];
  logic [17:0] vid_a   [2];
  logic [7:0]  vid_o   [2];

  logic [1:0]       cpu_ack, vid_ack, mem_w, busy;
  logic [1:0][7:0]  cpu_i, vid_i, mem_o, mem_i;
  logic [1:0][19:0] mem_a;

  mem_arbiter #(.VID_BASE(BASE0), .FIXED_PRIO(1'b0)) u_rr (
    .clock(clock), .reset_n(reset_n),
    .cpu_req(cpu_req[0]), .cpu_we(cpu_we[0]), .cpu_a(cpu_a[0]), .cpu_o(cpu_o[0]),
    .cpu_i(cpu_i[0]), .cpu_ack(cpu_ack[0]),
    .vid_req(vid_req[0]), .vid_we(vid_we[0]), .vid_a(vid_a[0]), .vid_o(vid_o[0]),
    .vid_i(vid_i[0]), .vid_ack(vid_ack[0]),
    .mem_a(mem_a[0]), .mem_o(mem_o[0]), .mem_w(mem_w[0]), .mem_i(mem_i[0]),
    .busy(busy[0])
  );

  mem_arbiter #(.VID_BASE(BASE1), .FIXED_PRIO(1'b1)) u_fp (
    .clock(clock), .reset_n(reset_n),
    .cpu_req(cpu_req[1]), .cpu_we(cpu_we[1]), .cpu_a(cpu_a[1]), .cpu_o(cpu_o[1]),
    .cpu_i(cpu_i[1]), .cpu_ack(cpu_ack[1]),
    .vid_req(vid_req[1]), .vid_we(vid_we[1]), .vid_a(vid_a[1]), .vid_o(vid_o[1]),
    .vid_i(vid_i[1]), .vid_ack(vid_ack[1]),
    .mem_a(mem_a[1]), .mem_o(mem_o[1]), .mem_w(mem_w[1]), .mem_i(mem_i[1]),
    .busy(busy[1])
  );

  // Power-up memory contents; chosen so that byte 0x00010 holds 0x03.
  function automatic logic [7:0] finit(input logic [19:0] a);
    return a[7:0] ^ a[15:8] ^ a[19:12] ^ 8'h13;
  endfunction

  // Synchronous memories: read data one clock after address, read-before-write.
  bit [7:0] tbmem [2][1048576];
  bit       tbwr  [2][1048576];
  always @(posedge clock) begin
    for (int i = 0; i < 2; i++) begin
      mem_i[i] <= tbwr[i][mem_a[i]] ? tbmem[i][mem_a[i]] : finit(mem_a[i]);
      if (mem_w[i]) begin
        tbmem[i][mem_a[i]] <= mem_o[i];
        tbwr[i][mem_a[i]]  <= 1'b1;
      end
    end
  end

  function automatic logic [7:0] tb_rd(input int i, input logic [19:0] a);
    return tbwr[i][a] ? tbmem[i][a] : finit(a);
  endfunction

  // Reference memory as seen by the requesters, updated at request time.
  bit [7:0] refm  [2][1048576];
  bit       refwr [2][1048576];
  logic [19:0] wlist [2][$];

  function automatic logic [7:0] ref_rd(input int i, input logic [19:0] a);
    return refwr[i][a] ? refm[i][a] : finit(a);
  endfunction

  function automatic logic [19:0] vphys(input int i, input logic [17:0] a);
    logic [19:0] b;
    b = (i == 0) ? BASE0 : BASE1;
    return b + {2'b00, a};
  endfunction

  typedef struct {
    logic [19:0] pa;
    logic        we;
    logic [7:0]  d;
    logic [7:0]  rd;
    int          nw;
  } txn_t;

  txn_t q [4][$];   // index = inst*2 + side (side 0 = CPU, 1 = VIDAC)
  int   alog [2][$];

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  bit rst_smp;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // One access from requester k; called and returning on a negedge.
  task automatic do_req(input int k, input logic we, input logic [19:0] a,
                        input logic [7:0] d, input int gap, output int lat);
    int   i;
    bit   s;
    int   n;
    txn_t e;
    i = k / 2;
    s = (k % 2) == 1;
    e.pa = s ? vphys(i, a[17:0]) : a;
    e.we = we;
    e.d  = d;
    e.rd = ref_rd(i, e.pa);
    e.nw = 0;
    if (we) begin
      refm[i][e.pa]  = d;
      refwr[i][e.pa] = 1'b1;
      wlist[i].push_back(e.pa);
    end
    q[k].push_back(e);
    if (s) begin
      vid_req[i] = 1'b1; vid_we[i] = we; vid_a[i] = a[17:0]; vid_o[i] = d;
    end else begin
      cpu_req[i] = 1'b1; cpu_we[i] = we; cpu_a[i] = a; cpu_o[i] = d;
    end
    lat = -1;
    n = 0;
    while (n < 40) begin
      @(negedge clock);
      n++;
      if (s ? vid_ack[i] : cpu_ack[i]) begin
        lat = n;
        break;
      end
    end
    if (lat < 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL req_timeout k=%0d: no ack after %0d cycles, ack required", k, n);
    end
    if (gap > 0) begin
      if (s) vid_req[i] = 1'b0; else cpu_req[i] = 1'b0;
      repeat (gap) @(negedge clock);
    end
  endtask

  function automatic logic [19:0] rand_addr(input int k);
    logic [19:0] r;
    r = 20'($urandom_range(0, 31));
    if ((k % 2) == 0) return 20'h40000 | r;
    if ($urandom_range(0, 1) == 1) return 20'h3FFE0 + r;
    return r;
  endfunction

  task automatic rand_thread(input int k, input int cnt);
    int lat;
    for (int n = 0; n < cnt; n++) begin
      do_req(k, 1'($urandom_range(0, 1)), rand_addr(k), 8'($urandom),
             (n == cnt - 1) ? 1 : $urandom_range(0, 3), lat);
    end
  endtask

  task automatic burst(input int k, input int cnt);
    int lat;
    for (int n = 0; n < cnt; n++) begin
      do_req(k, 1'b0, rand_addr(k), 8'h00, (n == cnt - 1) ? 2 : 0, lat);
    end
  endtask

  task automatic chk_order(input int i, input logic [7:0] pat, input int len, input string nm);
    chk({nm, "_count"}, alog[i].size(), len);
    for (int j = 0; j < len && j < alog[i].size(); j++) begin
      chk(nm, alog[i][j], {31'd0, pat[j]});
    end
  endtask

  always @(posedge clock) begin
    rst_smp <= reset_n;
    cyc     <= cyc + 1;
  end

  // Monitor state
  bit          pb1 [2];
  bit          pb2 [2];
  int          t_iss [2];
  logic [19:0] rec_a [2];
  logic        rec_w [2];
  logic [7:0]  rec_o [2];
  logic [7:0]  held_c [2];
  logic [7:0]  held_v [2];

  task automatic check_ack(input int i, input int s, input logic [7:0] data);
    int   k;
    int   o;
    txn_t e;
    k = i * 2 + s;
    o = i * 2 + (1 - s);
    if (q[k].size() == 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL unexpected_ack inst=%0d side=%0d: ack=1 with no request outstanding, required ack=0", i, s);
      return;
    end
    e = q[k].pop_front();
    chk("ack_latency", cyc - t_iss[i], 2);
    chk("mem_a", rec_a[i], e.pa);
    chk("mem_w_in_issue", rec_w[i], e.we);
    if (e.we) chk("mem_o", rec_o[i], e.d);
    chk("read_data", data, e.rd);
    chk("busy_at_ack", busy[i], 0);
    chk("fair_wait_le1", e.nw > 1, 0);
    if (q[o].size() > 0) q[o][0].nw = q[o][0].nw + 1;
    if (s == 1) held_v[i] = data; else held_c[i] = data;
    alog[i].push_back(s);
  endtask

  // Scoreboard monitor: acks, port timing and data hold
  always @(negedge clock) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst_smp) begin
        pb1[i] = 1'b0; pb2[i] = 1'b0; held_c[i] = '0; held_v[i] = '0;
      end else begin
        if (busy[i] && !pb1[i]) begin
          t_iss[i] = cyc; rec_a[i] = mem_a[i]; rec_w[i] = mem_w[i]; rec_o[i] = mem_o[i];
        end else begin
          chk("mem_w_outside_issue", mem_w[i], 0);
        end
        if (pb1[i] && !pb2[i]) chk("busy_in_wait", busy[i], 1);
        if (cpu_ack[i] && vid_ack[i]) chk("both_acks", 2'b11, 2'b00);
        if (cpu_ack[i]) check_ack(i, 0, cpu_i[i]); else chk("cpu_i_hold", cpu_i[i], held_c[i]);
        if (vid_ack[i]) check_ack(i, 1, vid_i[i]); else chk("vid_i_hold", vid_i[i], held_v[i]);
        pb2[i] = pb1[i];
        pb1[i] = busy[i];
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    for (int i = 0; i < 2; i++) begin
      cpu_req[i] = 0; cpu_we[i] = 0; cpu_a[i] = '0; cpu_o[i] = '0;
      vid_req[i] = 0; vid_we[i] = 0; vid_a[i] = '0; vid_o[i] = '0;
    end
    reset_n = 1'b0;
    repeat (3) @(negedge clock);
    for (int i = 0; i < 2; i++) begin
      chk("rst_cpu_i", cpu_i[i], 0);     chk("rst_vid_i", vid_i[i], 0);
      chk("rst_cpu_ack", cpu_ack[i], 0); chk("rst_vid_ack", vid_ack[i], 0);
      chk("rst_mem_a", mem_a[i], 0);     chk("rst_mem_o", mem_o[i], 0);
      chk("rst_mem_w", mem_w[i], 0);     chk("rst_busy", busy[i], 0);
    end
    reset_n = 1'b1;

    // CPU read of a preloaded byte: 3-cycle latency, data 0x03
    do_req(0, 1'b0, 20'h00010, 8'h00, 2, lat);
    chk("t1_cpu_latency", lat, 3);
    chk("t1_cpu_i", cpu_i[0], 8'h03);

    // VIDAC write lands at base + offset
    do_req(1, 1'b1, 20'h00005, 8'hAA, 2, lat);
    chk("t2_mem_A0005", tb_rd(0, 20'hA0005), 8'hAA);

    // Both held from the same edge: C,V,C,V,... on either arbiter
    alog[0].delete(); alog[1].delete();
    fork
      burst(0, 4); burst(1, 4); burst(2, 4); burst(3, 4);
    join
    chk_order(0, 8'b10101010, 8, "t3_rr_order");
    chk_order(1, 8'b10101010, 8, "t3_fp_order");

    // Make CPU the last winner, then tie: round-robin picks VIDAC, fixed picks CPU
    fork
      burst(0, 1); burst(2, 1);
    join
    alog[0].delete(); alog[1].delete();
    fork
      burst(0, 4); burst(1, 1); burst(2, 4); burst(3, 1);
    join
    chk_order(0, 8'b00000001, 5, "t4_rr_order");
    chk_order(1, 8'b00000010, 5, "t4_fp_order");

    // VIDAC address wraps past the top of the 20-bit space
    do_req(3, 1'b1, 20'h1FFFF, 8'h5A, 2, lat);
    chk("t5_wrap_mem", tb_rd(1, 20'h0FFFF), 8'h5A);
    do_req(3, 1'b0, 20'h1FFFF, 8'h00, 2, lat);
    chk("t5_wrap_readback", vid_i[1], 8'h5A);

    // Reset during WAIT of a CPU read aborts it with no ack
    cpu_req[0] = 1'b1; cpu_we[0] = 1'b0; cpu_a[0] = 20'h40010;
    @(negedge clock);
    chk("t6_busy_issue", busy[0], 1);
    @(negedge clock);
    chk("t6_busy_wait", busy[0], 1);
    reset_n = 1'b0;
    @(negedge clock);
    chk("t6_busy", busy[0], 0);
    chk("t6_cpu_ack", cpu_ack[0], 0);
    chk("t6_mem_w", mem_w[0], 0);
    cpu_req[0] = 1'b0;
    reset_n = 1'b1;
    repeat (6) begin
      @(negedge clock);
      chk("t6_no_ack", cpu_ack[0], 0);
    end

    // Randomized traffic on both arbiters
    fork
      rand_thread(0, 50); rand_thread(1, 50); rand_thread(2, 50); rand_thread(3, 50);
    join
    repeat (5) @(negedge clock);
    for (int k = 0; k < 4; k++) chk("queue_drained", q[k].size(), 0);
    for (int i = 0; i < 2; i++) begin
      for (int j = 0; j < wlist[i].size(); j++) begin
        chk("mem_contents", tb_rd(i, wlist[i][j]), ref_rd(i, wlist[i][j]));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
